// File: rtl/net_packet_rx.sv
// -----------------------------------------------------------------------------
// net_packet_rx
//
// Boot-time network receiver for one core. Packets arriving on the network
// input that carry this core's ID are decoded into registered write strobes
// for the instruction memory, the register file, the barrier mask and the
// PC. The block also tracks the core's boot state (IDLE/LOAD/RUN/HALT) and
// keeps the core stalled (run_o = 0) until a PC packet releases it.
//
// Ports
//   clk             clock, all logic on posedge
//   reset           synchronous, active-high; highest priority input
//   net_packet_i    network packet, sampled every edge, no backpressure
//   halt_i          core reached DONE/FAIL (pulse)
//   imem_wen_o      instruction write strobe, with imem_addr_o / imem_data_o
//   rf_wen_o        register write strobe, with rf_addr_o / rf_data_o
//   pc_wen_o        PC load strobe, with pc_o
//   barrier_mask_o  barrier mask, held until the next BAR packet
//   run_o           core may fetch (state RUN)
//   state_o         0 IDLE, 1 LOAD, 2 RUN, 3 HALT
//   instr_cnt_o     accepted INSTR packets, saturating
//   reg_cnt_o       accepted REG packets, saturating
//   err_o           sticky protocol error
//
// Build option
//   NET_RX_CHECK_EN  when defined, INSTR/REG packets arriving in RUN are
//                    dropped and flag err_o, as do undefined opcodes; when
//                    undefined, every write is honoured and err_o is 0.
//
// The packet address field is as wide as the default imem address; widening
// IMEM_ADDR_W_P or RF_ADDR_W_P beyond net_addr_width_gp is not supported.
// -----------------------------------------------------------------------------

package net_packet_rx_pkg;

   localparam int net_id_width_gp   = 5;
   localparam int net_addr_width_gp = 10;
   localparam int mask_length_gp    = 16;
   localparam int rs_imm_size_gp    = 6;

   localparam logic [2:0] NET_OP_NULL  = 3'd0;
   localparam logic [2:0] NET_OP_INSTR = 3'd1;
   localparam logic [2:0] NET_OP_REG   = 3'd2;
   localparam logic [2:0] NET_OP_PC    = 3'd3;
   localparam logic [2:0] NET_OP_BAR   = 3'd4;

   typedef struct packed {
      logic [net_id_width_gp-1:0]   ID;
      logic [2:0]                   net_op;
      logic [net_addr_width_gp-1:0] net_addr;
      logic [31:0]                  net_data;
   } net_packet_s;

endpackage

module net_packet_rx
   import net_packet_rx_pkg::*;
#(
   parameter int CORE_ID_P     = 1,
   parameter int IMEM_ADDR_W_P = 10,
   parameter int RF_ADDR_W_P   = rs_imm_size_gp,
   parameter int MASK_W_P      = mask_length_gp,
   parameter int PC_W_P        = 10,
   parameter int CNT_W_P       = 11
) (
   input  logic                     clk,
   input  logic                     reset,
   input  net_packet_s              net_packet_i,
   input  logic                     halt_i,
   output logic                     imem_wen_o,
   output logic [IMEM_ADDR_W_P-1:0] imem_addr_o,
   output logic [15:0]              imem_data_o,
   output logic                     rf_wen_o,
   output logic [RF_ADDR_W_P-1:0]   rf_addr_o,
   output logic [31:0]              rf_data_o,
   output logic                     pc_wen_o,
   output logic [PC_W_P-1:0]        pc_o,
   output logic [MASK_W_P-1:0]      barrier_mask_o,
   output logic                     run_o,
   output logic [1:0]               state_o,
   output logic [CNT_W_P-1:0]       instr_cnt_o,
   output logic [CNT_W_P-1:0]       reg_cnt_o,
   output logic                     err_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_HALT = 2'd3
   } state_e;

   localparam logic [net_id_width_gp-1:0] CORE_ID_L = net_id_width_gp'(CORE_ID_P);
   localparam logic [CNT_W_P-1:0]         CNT_MAX_L = {CNT_W_P{1'b1}};
   localparam logic [CNT_W_P-1:0]         CNT_ONE_L = CNT_W_P'(1);

   state_e                   state_q, state_d;
   logic                     acc_s;
   logic                     is_instr_s, is_reg_s, is_pc_s, is_bar_s;
   logic                     wr_block_s;
   logic                     instr_fire_s, reg_fire_s;

   logic                     imem_wen_q, imem_wen_d;
   logic [IMEM_ADDR_W_P-1:0] imem_addr_q, imem_addr_d;
   logic [15:0]              imem_data_q, imem_data_d;
   logic                     rf_wen_q, rf_wen_d;
   logic [RF_ADDR_W_P-1:0]   rf_addr_q, rf_addr_d;
   logic [31:0]              rf_data_q, rf_data_d;
   logic                     pc_wen_q, pc_wen_d;
   logic [PC_W_P-1:0]        pc_q, pc_d;
   logic [MASK_W_P-1:0]      mask_q, mask_d;
   logic                     run_q, run_d;
   logic [CNT_W_P-1:0]       instr_cnt_q, instr_cnt_d;
   logic [CNT_W_P-1:0]       reg_cnt_q, reg_cnt_d;

`ifdef NET_RX_CHECK_EN
   logic                     op_undef_s;
   logic                     err_q, err_d;
`endif

   // Packet decode: classify this cycle's packet and decide which writes fire.
   always_comb begin
      acc_s      = (net_packet_i.ID == CORE_ID_L) && (net_packet_i.net_op != NET_OP_NULL);
      is_instr_s = acc_s && (net_packet_i.net_op == NET_OP_INSTR);
      is_reg_s   = acc_s && (net_packet_i.net_op == NET_OP_REG);
      is_pc_s    = acc_s && (net_packet_i.net_op == NET_OP_PC);
      is_bar_s   = acc_s && (net_packet_i.net_op == NET_OP_BAR);
`ifdef NET_RX_CHECK_EN
      // A running core must not have its program or registers rewritten.
      wr_block_s = (state_q == ST_RUN) && (is_instr_s || is_reg_s);
      op_undef_s = acc_s && !(is_instr_s || is_reg_s || is_pc_s || is_bar_s);
`else
      wr_block_s = 1'b0;
`endif
      instr_fire_s = is_instr_s && !wr_block_s;
      reg_fire_s   = is_reg_s && !wr_block_s;
   end

   // Boot-state next-state logic; halt_i takes precedence over a PC packet in RUN.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (is_pc_s) begin
               state_d = ST_RUN;
            end else if (is_instr_s || is_reg_s || is_bar_s) begin
               state_d = ST_LOAD;
            end else begin
               state_d = state_q;
            end
         end
         ST_LOAD: begin
            if (is_pc_s) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_RUN: begin
            if (halt_i) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Write datapath: strobes pulse for one cycle, payload registers hold.
   always_comb begin
      imem_wen_d  = instr_fire_s;
      imem_addr_d = imem_addr_q;
      imem_data_d = imem_data_q;
      rf_wen_d    = reg_fire_s;
      rf_addr_d   = rf_addr_q;
      rf_data_d   = rf_data_q;
      pc_wen_d    = is_pc_s;
      pc_d        = pc_q;
      mask_d      = mask_q;
      instr_cnt_d = instr_cnt_q;
      reg_cnt_d   = reg_cnt_q;
      run_d       = (state_d == ST_RUN);

      if (instr_fire_s) begin
         imem_addr_d = net_packet_i.net_addr[IMEM_ADDR_W_P-1:0];
         imem_data_d = net_packet_i.net_data[15:0];
         if (instr_cnt_q != CNT_MAX_L) begin
            instr_cnt_d = instr_cnt_q + CNT_ONE_L;
         end else begin
            instr_cnt_d = instr_cnt_q;
         end
      end else begin
         instr_cnt_d = instr_cnt_q;
      end

      if (reg_fire_s) begin
         rf_addr_d = net_packet_i.net_addr[RF_ADDR_W_P-1:0];
         rf_data_d = net_packet_i.net_data;
         if (reg_cnt_q != CNT_MAX_L) begin
            reg_cnt_d = reg_cnt_q + CNT_ONE_L;
         end else begin
            reg_cnt_d = reg_cnt_q;
         end
      end else begin
         reg_cnt_d = reg_cnt_q;
      end

      if (is_pc_s) begin
         pc_d = net_packet_i.net_data[PC_W_P-1:0];
      end else begin
         pc_d = pc_q;
      end

      if (is_bar_s) begin
         mask_d = net_packet_i.net_data[MASK_W_P-1:0];
      end else begin
         mask_d = mask_q;
      end
   end

   // State and output registers; reset drops any packet sampled on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         imem_wen_q  <= 1'b0;
         imem_addr_q <= '0;
         imem_data_q <= 16'h0000;
         rf_wen_q    <= 1'b0;
         rf_addr_q   <= '0;
         rf_data_q   <= 32'h0000_0000;
         pc_wen_q    <= 1'b0;
         pc_q        <= '0;
         mask_q      <= '0;
         run_q       <= 1'b0;
         instr_cnt_q <= '0;
         reg_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         imem_wen_q  <= imem_wen_d;
         imem_addr_q <= imem_addr_d;
         imem_data_q <= imem_data_d;
         rf_wen_q    <= rf_wen_d;
         rf_addr_q   <= rf_addr_d;
         rf_data_q   <= rf_data_d;
         pc_wen_q    <= pc_wen_d;
         pc_q        <= pc_d;
         mask_q      <= mask_d;
         run_q       <= run_d;
         instr_cnt_q <= instr_cnt_d;
         reg_cnt_q   <= reg_cnt_d;
      end
   end

`ifdef NET_RX_CHECK_EN
   // Sticky error: set by writes blocked in RUN or by an undefined opcode.
   always_comb begin
      err_d = err_q | wr_block_s | op_undef_s;
   end

   // Error flag register.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign imem_wen_o     = imem_wen_q;
   assign imem_addr_o    = imem_addr_q;
   assign imem_data_o    = imem_data_q;
   assign rf_wen_o       = rf_wen_q;
   assign rf_addr_o      = rf_addr_q;
   assign rf_data_o      = rf_data_q;
   assign pc_wen_o       = pc_wen_q;
   assign pc_o           = pc_q;
   assign barrier_mask_o = mask_q;
   assign run_o          = run_q;
   assign state_o        = state_q;
   assign instr_cnt_o    = instr_cnt_q;
   assign reg_cnt_o      = reg_cnt_q;

endmodule
